// File: rtl/izh_pkg.sv
// Shared constants for the Izhikevich neuron scheduler: model constants and
// the sweep FSM state encoding.
package izh_pkg;

   // Neuron model constants
   localparam logic [7:0]  THRESH  = 8'd208;
   localparam logic [7:0]  V_RESET = 8'd0;
   localparam logic [15:0] U_INC   = 16'd1024;
   localparam logic [15:0] A       = 16'd24;
   localparam logic [15:0] B       = 16'd100;

   // Sweep FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_FETCH = 3'd1;
   localparam state_t ST_CALC  = 3'd2;
   localparam state_t ST_STORE = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/izh_scheduler_if.sv
// Control/data bundle between a host and the neuron scheduler.
interface izh_scheduler_if #(
   parameter int N_NEURONS = 4,
   parameter int IDX_W     = 2
);
   logic                 enable;
   logic                 tick;
   logic                 cur_we;
   logic [IDX_W-1:0]     cur_sel;
   logic [7:0]           cur_data;
   logic [IDX_W-1:0]     v_sel;
   logic [7:0]           v_out;
   logic                 busy;
   logic                 done;
   logic [N_NEURONS-1:0] spike_vec;

   modport master (
      output enable, tick, cur_we, cur_sel, cur_data, v_sel,
      input  v_out, busy, done, spike_vec
   );

   modport slave (
      input  enable, tick, cur_we, cur_sel, cur_data, v_sel,
      output v_out, busy, done, spike_vec
   );
endinterface

// File: rtl/izh_update.sv
// One-neuron update datapath: combinational Izhikevich step on the latched
// operands, captured in a single result register while calc_en_i is high.
module izh_update
   import izh_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        calc_en_i,
   input  logic [7:0]  v_i,
   input  logic [15:0] u_i,
   input  logic [7:0]  cur_i,
   output logic [7:0]  v_next_o,
   output logic [15:0] u_next_o,
   output logic        spike_o
);

   logic [15:0] v16;
   logic [15:0] sq_full;
   logic [15:0] sq;
   logic [15:0] lin;
   logic [15:0] v_sum;
   logic [15:0] diff;
   logic [15:0] prod;
   logic [15:0] du;
   logic [15:0] u_calc;
   logic [7:0]  v_calc;
   logic        spike_d;

   // All arithmetic is deliberately 16-bit modular; the square can wrap for large v.
   assign v16     = {8'd0, v_i};
   assign sq_full = 16'd2 * v16 * v16;
   assign sq      = sq_full >> 7;
   assign lin     = (16'd5 * v16) >> 7;
   assign v_sum   = sq + lin - u_i + {8'd0, cur_i};
   assign v_calc  = 8'(v_sum);
   assign diff    = B * v16 - u_i;
   assign prod    = A * diff;
   assign du      = prod >> 7;
   assign u_calc  = u_i + du;
   assign spike_d = (v_i >= THRESH);

   logic [7:0]  v_next_q;
   logic [15:0] u_next_q;
   logic        spike_q;

   // Capture the update result (spike reset or integration step) in CALC.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_next_q <= '0;
         u_next_q <= '0;
         spike_q  <= 1'b0;
      end else if (calc_en_i) begin
         spike_q <= spike_d;
         if (spike_d) begin
            v_next_q <= V_RESET;
            u_next_q <= u_i + U_INC;
         end else begin
            v_next_q <= v_calc;
            u_next_q <= u_calc;
         end
      end
   end

   assign v_next_o = v_next_q;
   assign u_next_o = u_next_q;
   assign spike_o  = spike_q;

endmodule

// File: rtl/izh_scheduler.sv
// Time-multiplexed Izhikevich neuron scheduler: one tick sweeps every neuron
// through FETCH/CALC/STORE using a single shared update unit.
module izh_scheduler
   import izh_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int IDX_W     = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   izh_scheduler_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [7:0]           v_q   [N_NEURONS];
   logic [15:0]          u_q   [N_NEURONS];
   logic [7:0]           cur_q [N_NEURONS];
   logic [7:0]           op_v_q;
   logic [15:0]          op_u_q;
   logic [7:0]           op_cur_q;
   logic [N_NEURONS-1:0] shadow_q;
   logic [N_NEURONS-1:0] spike_vec_q;
   logic                 done_q;
   logic [7:0]           upd_v;
   logic [15:0]          upd_u;
   logic                 upd_spike;

   // Sweep sequencing: accept a tick only when idle and enabled, then walk the indices.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.tick && bus.enable) begin
               state_d = ST_FETCH;
               idx_d   = '0;
            end
         end
         ST_FETCH: state_d = ST_CALC;
         ST_CALC:  state_d = ST_STORE;
         ST_STORE: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_FETCH;
               idx_d   = idx_q + 1'b1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM state and neuron index registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Operand latch in FETCH; a same-edge current write is therefore not seen.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_v_q   <= '0;
         op_u_q   <= '0;
         op_cur_q <= '0;
      end else if (state_q == ST_FETCH) begin
         op_v_q   <= v_q[idx_q];
         op_u_q   <= u_q[idx_q];
         op_cur_q <= cur_q[idx_q];
      end
   end

   izh_update u_update (
      .clk       (clk),
      .reset_n   (reset_n),
      .calc_en_i (state_q == ST_CALC),
      .v_i       (op_v_q),
      .u_i       (op_u_q),
      .cur_i     (op_cur_q),
      .v_next_o  (upd_v),
      .u_next_o  (upd_u),
      .spike_o   (upd_spike)
   );

   // Host-written input currents, accepted in any state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_NEURONS; i++) cur_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_NEURONS; i++) begin
            if (bus.cur_we && (bus.cur_sel == IDX_W'(i))) cur_q[i] <= bus.cur_data;
         end
      end
   end

   // Membrane state write-back in STORE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            v_q[i] <= '0;
            u_q[i] <= '0;
         end
      end else if (state_q == ST_STORE) begin
         v_q[idx_q] <= upd_v;
         u_q[idx_q] <= upd_u;
      end
   end

   // Spike collection in a shadow vector, published together with the done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q    <= '0;
         spike_vec_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= (state_q == ST_DONE);
         if (state_q == ST_STORE) shadow_q[idx_q] <= upd_spike;
         if (state_q == ST_DONE) begin
            spike_vec_q <= shadow_q;
            shadow_q    <= '0;
         end
      end
   end

   assign bus.v_out     = v_q[bus.v_sel];
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.spike_vec = spike_vec_q;

endmodule

// File: tb/tb_izh_scheduler.sv
// Scoreboard bench for izh_scheduler: stimulus pushes expected sweep results,
// a done-driven monitor pops and compares spike_vec and latency.
module tb_izh_scheduler;

   localparam int N   = 4;
   localparam int LAT = 3 * N + 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_done = 0;

   typedef struct {
      logic [3:0] spk;
      int         acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   mv[N];
   int   mu[N];
   int   mc[N];

   izh_scheduler_if #(.N_NEURONS(N), .IDX_W(2)) bus ();

   izh_scheduler #(.N_NEURONS(N), .IDX_W(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Reference neuron model with explicit 16-bit wrap; returns the spike bits of one sweep.
   function automatic logic [3:0] model_sweep();
      logic [3:0] spk;
      spk = '0;
      for (int i = 0; i < N; i++) begin
         int v, u, c, t;
         v = mv[i]; u = mu[i]; c = mc[i];
         if (v >= 208) begin
            spk[i] = 1'b1;
            mv[i]  = 0;
            mu[i]  = (u + 1024) & 'hFFFF;
         end else begin
            t     = ((2 * v * v) & 'hFFFF) >> 7;
            mv[i] = (t + ((5 * v) >> 7) - u + c) & 'hFF;
            mu[i] = (u + (((((100 * v - u) & 'hFFFF) * 24) & 'hFFFF) >> 7)) & 'hFFFF;
         end
      end
      return spk;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = 0; mu[i] = 0; mc[i] = 0;
      end
   endtask

   task automatic write_cur(input int sel, input int data);
      @(negedge clk);
      bus.cur_we = 1'b1; bus.cur_sel = 2'(sel); bus.cur_data = 8'(data);
      @(negedge clk);
      bus.cur_we = 1'b0;
      mc[sel] = data;
      $display("write cur[%0d] = %0d", sel, data);
   endtask

   task automatic do_tick(input bit accept);
      logic [3:0] spk;
      @(negedge clk);
      bus.tick = 1'b1;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      if (accept) begin
         spk = model_sweep();
         sb.push_back('{spk: spk, acc: cyc});
         chk("busy_rise", int'(bus.busy), 1);
      end
      $display("tick at cycle %0d (accept expected=%0d)", cyc, accept);
   endtask

   task automatic wait_sweep();
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
      if (sb.size() != 0) chk("sweep_timeout", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic check_v(input int i, input int exp, input string nm);
      @(negedge clk);
      bus.v_sel = 2'(i);
      #1;
      chk(nm, int'(bus.v_out), exp);
   endtask

   task automatic check_model_v();
      for (int i = 0; i < N; i++) check_v(i, mv[i], $sformatf("v_model[%0d]", i));
   endtask

   // Monitor: every done pulse must match the oldest expected sweep.
   always @(negedge clk) begin
      if (reset_n && bus.done) begin
         n_done++;
         $display("done at cycle %0d spike_vec=%b", cyc, bus.spike_vec);
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("spike_vec", int'(bus.spike_vec), int'(mon_e.spk));
            chk("latency", cyc - mon_e.acc + 1, LAT);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      bit any_busy;
      bus.enable = 1'b0; bus.tick = 1'b0; bus.cur_we = 1'b0;
      bus.cur_sel = '0; bus.cur_data = '0; bus.v_sel = '0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      bus.enable = 1'b1;

      // Reset state
      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_spike_vec", int'(bus.spike_vec), 0);
      check_model_v();

      // Single sweep with current 10 on neuron 0
      write_cur(0, 10);
      do_tick(1);
      wait_sweep();
      check_v(0, 10, "v0_after_first");
      check_model_v();

      // Drive neuron 2 to threshold, then spike on the next sweep
      write_cur(2, 208);
      do_tick(1);
      wait_sweep();
      check_v(2, 208, "v2_at_thresh");
      check_v(0, 11, "v0_second");
      do_tick(1);
      wait_sweep();
      chk("spike2_bit", int'(bus.spike_vec[2]), 1);
      check_v(2, 0, "v2_after_spike");
      check_v(0, 80, "v0_third");
      check_model_v();

      // Tick while busy is dropped: exactly one done
      d0 = n_done;
      do_tick(1);
      repeat (3) @(posedge clk);
      do_tick(0);
      wait_sweep();
      repeat (20) @(posedge clk);
      chk("one_done_when_busy_tick", n_done - d0, 1);
      chk("spike_vec_holds", int'(bus.spike_vec), int'(sb.size() == 0 ? mon_e.spk : 4'hF));
      check_model_v();

      // Tick with enable low is ignored
      bus.enable = 1'b0;
      d0 = n_done;
      do_tick(0);
      any_busy = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.busy) any_busy = 1'b1;
      end
      chk("busy_enable_low", int'(any_busy), 0);
      chk("no_done_enable_low", n_done - d0, 0);

      // Enable dropped mid-sweep: sweep still completes on time
      bus.enable = 1'b1;
      do_tick(1);
      repeat (3) @(negedge clk);
      bus.enable = 1'b0;
      wait_sweep();
      bus.enable = 1'b1;
      check_model_v();

      // Current write to neuron 1 during its FETCH cycle uses the old value
      do_tick(1);
      repeat (4) @(negedge clk);
      bus.cur_we = 1'b1; bus.cur_sel = 2'd1; bus.cur_data = 8'd50;
      @(negedge clk);
      bus.cur_we = 1'b0;
      wait_sweep();
      mc[1] = 50;
      check_v(1, 0, "v1_old_current");
      do_tick(1);
      wait_sweep();
      check_v(1, 50, "v1_new_current");
      check_model_v();

      // Asynchronous reset mid-sweep discards it
      do_tick(1);
      repeat (4) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      sb.delete();
      model_reset();
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_done", int'(bus.done), 0);
      chk("midrst_spike_vec", int'(bus.spike_vec), 0);
      for (int i = 0; i < N; i++) begin
         bus.v_sel = 2'(i);
         #1;
         chk($sformatf("midrst_v[%0d]", i), int'(bus.v_out), 0);
      end
      d0 = n_done;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(posedge clk);
      chk("no_done_after_reset", n_done - d0, 0);
      write_cur(0, 10);
      do_tick(1);
      wait_sweep();
      check_v(0, 10, "v0_after_reset_sweep");
      check_model_v();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/izh_scheduler.md
IZH_SCHEDULER -- requirements
Module: izh_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4, number of time-multiplexed neurons (2..16).
REQ-002 Parameter IDX_W, default 2, neuron index width, equal to clog2(N_NEURONS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  sweep permission; a tick is accepted only while high.
REQ-006 tick  input  1  single-cycle request to update all neurons once.
REQ-007 cur_we  input  1  write strobe for the per-neuron input-current register.
REQ-008 cur_sel  input  IDX_W  target neuron for cur_we.
REQ-009 cur_data  input  8  unsigned input current value.
REQ-010 v_sel  input  IDX_W  neuron whose membrane value drives v_out.
REQ-011 v_out  output  8  stored v of neuron v_sel, combinational read.
REQ-012 busy  output  1  high from tick acceptance until done.
REQ-013 done  output  1  one-cycle pulse marking sweep completion.
REQ-014 spike_vec  output  N_NEURONS  bit i high if neuron i spiked in the last completed sweep.

Function
REQ-015 State per neuron: v (8 bit), u (16 bit), current (8 bit), held in register arrays.
REQ-016 FSM states: IDLE, FETCH, CALC, STORE, DONE.
REQ-017 IDLE->FETCH on tick&enable; index=0; busy rises the cycle after acceptance.
REQ-018 FETCH: latch v[idx], u[idx], current[idx] into update-unit operands; ->CALC.
REQ-019 CALC: update unit registers v_next, u_next, spike; ->STORE.
REQ-020 STORE: write v_next/u_next to idx, set shadow spike bit idx; ->FETCH with idx+1, or ->DONE if idx==N_NEURONS-1.
REQ-021 DONE: copy shadow to spike_vec, clear shadow, pulse done, ->IDLE; busy low in IDLE.
REQ-022 Latency: done asserted exactly 3*N_NEURONS+2 cycles after the accepting tick edge (14 for N=4).
REQ-023 Spike rule: spike = (v >= THRESH); if set, v_next = V_RESET and u_next = u + U_INC.
REQ-024 Otherwise v_next = ((2*v*v)>>7) + ((5*v)>>7) - u + current, computed in 16 bits, low 8 bits kept.
REQ-025 Otherwise u_next = u + ((A*(B*v - u))>>7), all 16-bit unsigned, wrap-around on overflow.
REQ-026 tick while busy, or while enable low, is ignored (not queued).
REQ-027 enable deassert mid-sweep does not abort; the sweep completes.
REQ-028 cur_we accepted in any state; a write coinciding with FETCH of the same neuron is not seen by that fetch (old value used).
REQ-029 spike_vec holds its value between DONE states.

Reset
REQ-030 reset_n low asynchronously: FSM->IDLE, idx=0, all v=0, u=0, current=0, shadow=0, spike_vec=0, busy=0, done=0.
REQ-031 Reset mid-sweep discards the partial sweep; no done pulse follows.

Structure
REQ-032 Package izh_pkg holds THRESH=208, V_RESET=0, U_INC=1024, A=24, B=100, FSM state enumeration.
REQ-033 Sub-module izh_update implements REQ-023..025 with one registered stage (operands in FETCH, result valid in STORE).

Verification
REQ-034 Reset, write current 10 to neuron 0, tick -> done 14 cycles later, v of neuron 0 = 10, spike_vec=0000.
REQ-035 Force neuron 2 to v=208, u=0 via repeated ticks with current 208 -> that sweep: spike_vec[2]=1, v=0, u=1024.
REQ-036 tick asserted while busy -> no extra sweep; exactly one done pulse.
REQ-037 reset_n low at cycle 5 of a sweep -> all outputs 0 immediately; no done; next tick sweeps normally.
REQ-038 cur_we to neuron 1 in its FETCH cycle with 50 (old 0) -> that sweep uses 0; next sweep uses 50.
REQ-039 enable low at tick -> busy stays 0; enable dropped mid-sweep -> done still at cycle 14.
